// File: rtl/simd_pkg.sv
// Shared SIMD datapath constants, types and helpers for the AES vector unit.
package simd_pkg;

  localparam int BITS   = 128;
  localparam int WORD   = 32;
  localparam int BEATS  = BITS / WORD;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int REG_W  = $clog2(DEPTH);
  localparam int BEAT_W = $clog2(BEATS);

  typedef logic [BITS-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } vlu_state_t;

  // Byte address of a beat; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [BEAT_W-1:0] beat);
    return base + (ADDR_W'(beat) << 2);
  endfunction

endpackage

// File: rtl/vector_load_unit_if.sv
// Data-memory read port and register-file write port of the vector load unit.
interface vector_load_unit_if;
  import simd_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD-1:0]   mem_rdata;
  logic              mem_valid;

  logic              writeEn;
  logic [REG_W-1:0]  addressw;
  vec_t              writeData;

  modport master (
    output mem_req, mem_addr, writeEn, addressw, writeData,
    input  mem_rdata, mem_valid
  );

  modport slave (
    input  mem_req, mem_addr, writeEn, addressw, writeData,
    output mem_rdata, mem_valid
  );

endinterface

// File: rtl/vector_load_unit.sv
// Gathers four 32-bit memory words into one 128-bit vector and writes it to the vector register file.
module vector_load_unit
  import simd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [REG_W-1:0]  dest_reg,
  output logic              busy,
  output logic              done,
  vector_load_unit_if.master bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_WRITE = WRITE;

  logic [1:0]        state_p0;
  logic [BEAT_W-1:0] beat_p0;
  logic [ADDR_W-1:0] base_p0;
  logic [REG_W-1:0]  dest_p0;
  vec_t              buf_p0;

  // Control, address and lane buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= ST_IDLE;
      beat_p0  <= '0;
      base_p0  <= '0;
      dest_p0  <= '0;
      buf_p0   <= '0;
    end else begin
      case (state_p0)
        ST_IDLE: begin
          if (start) begin
            base_p0  <= base_addr & ~ADDR_W'(3);
            dest_p0  <= dest_reg;
            beat_p0  <= '0;
            buf_p0   <= '0;
            state_p0 <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.mem_valid) begin
            buf_p0[WORD*beat_p0 +: WORD] <= bus.mem_rdata;
            if (beat_p0 == BEAT_W'(BEATS-1)) state_p0 <= ST_WRITE;
            else                              beat_p0  <= beat_p0 + 1'b1;
          end
        end
        ST_WRITE: state_p0 <= ST_IDLE;
        default:  state_p0 <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only
  assign busy          = (state_p0 != ST_IDLE);
  assign done          = (state_p0 == ST_WRITE);
  assign bus.mem_req   = (state_p0 == ST_FETCH);
  assign bus.mem_addr  = (state_p0 == ST_FETCH) ? beat_addr(base_p0, beat_p0) : '0;
  assign bus.writeEn   = (state_p0 == ST_WRITE);
  assign bus.addressw  = dest_p0;
  assign bus.writeData = buf_p0;

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed bench for vector_load_unit with a 64-word memory model and a register-file model.
module tb_vector_load_unit;
  import simd_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [REG_W-1:0]  dest_reg;
  logic              busy;
  logic              done;

  vector_load_unit_if bus();

  vector_load_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .dest_reg  (dest_reg),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stall_cnt = 0;
  int wait_n = 0;
  int wr_count = 0;
  logic [31:0] mem [64];
  vec_t        rf  [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory answers after wait_n stall cycles per beat
  always_comb begin
    bus.mem_valid = bus.mem_req && (stall_cnt >= wait_n);
    bus.mem_rdata = mem[bus.mem_addr[7:2]];
  end

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_valid) stall_cnt <= 0;
    else                               stall_cnt <= stall_cnt + 1;
  end

  always @(posedge clk) begin
    if (bus.writeEn) begin
      rf[bus.addressw] <= bus.writeData;
      wr_count         <= wr_count + 1;
    end
  end

  typedef struct {
    logic [31:0]      base;
    logic [3:0]       dest;
    int               waits;
    int               poke;
    logic [3:0][31:0] w;
    logic [3:0][31:0] a;
    logic [127:0]     data;
    int               lat;
  } vec_rec_t;

  vec_rec_t vecs [4];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] outs_flat();
    return {88'd0, busy, done, bus.mem_req, bus.mem_addr, bus.writeEn, bus.addressw, bus.writeData};
  endfunction

  task automatic run_load(input vec_rec_t v);
    int t0, lat, nb, wc0;
    bit seen, stable, prev_stall;
    logic [31:0] prev;
    logic [3:0][31:0] got;
    got = '0; nb = 0; seen = 1'b0; stable = 1'b1; prev_stall = 1'b0; prev = '0; lat = -1;
    wait_n = v.waits;
    for (int i = 0; i < 4; i++) mem[v.a[i][7:2]] = v.w[i];
    wc0 = wr_count;
    @(negedge clk);
    base_addr = v.base; dest_reg = v.dest; start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc; start = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (v.poke > 0 && k == v.poke - 1) begin
        start = 1'b1; dest_reg = 4'd9; base_addr = 32'h40;
      end else start = 1'b0;
      if (prev_stall && bus.mem_req && bus.mem_addr !== prev) stable = 1'b0;
      if (bus.mem_req && bus.mem_valid && nb < 4) begin got[nb] = bus.mem_addr; nb++; end
      prev_stall = bus.mem_req && !bus.mem_valid;
      prev = bus.mem_addr;
      if (bus.writeEn) begin
        seen = 1'b1;
        lat  = cyc - t0;
        chk("addressw",  256'(bus.addressw),  256'(v.dest));
        chk("writeData", 256'(bus.writeData), 256'(v.data));
        chk("done_with_writeEn", 256'({done, busy}), 256'(2'b11));
      end
    end
    start = 1'b0;
    if (!seen) chk("write_timeout", 256'(0), 256'(1));
    for (int i = 0; i < 4; i++) chk($sformatf("mem_addr[%0d]", i), 256'(got[i]), 256'(v.a[i]));
    chk("addr_stable_in_stall", 256'(stable), 256'(1));
    chk("latency", 256'(lat), 256'(v.lat));
    @(negedge clk);
    chk("write_pulse_end", 256'({bus.writeEn, done, busy}), 256'(0));
    chk("write_count", 256'(wr_count - wc0), 256'(1));
    chk("rf_readback", 256'(rf[v.dest]), 256'(v.data));
  endtask

  initial begin
    vec_rec_t r;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < DEPTH; i++) rf[i] = '0;

    vecs[0] = '{32'h100, 4'd5, 0, 0,
                {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                {32'h10C, 32'h108, 32'h104, 32'h100},
                128'h44444444_33333333_22222222_11111111, 4};
    vecs[1] = '{32'h100, 4'd5, 2, 0,
                {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                {32'h10C, 32'h108, 32'h104, 32'h100},
                128'h44444444_33333333_22222222_11111111, 12};
    vecs[2] = '{32'hFFFFFFFE, 4'd3, 0, 0,
                {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0},
                {32'h00000008, 32'h00000004, 32'h00000000, 32'hFFFFFFFC},
                128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 4};
    vecs[3] = '{32'h200, 4'd7, 1, 2,
                {32'hCAFEF00D, 32'hDEADBEEF, 32'h89ABCDEF, 32'h01234567},
                {32'h20C, 32'h208, 32'h204, 32'h200},
                128'hCAFEF00D_DEADBEEF_89ABCDEF_01234567, 8};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; dest_reg = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle_outputs[%0d]", i), outs_flat(), 256'(0));
    end

    for (int i = 0; i < 4; i++) run_load(vecs[i]);

    // Reset during beat 2 must abort without a write
    begin
      int wc0;
      wait_n = 0;
      wc0 = wr_count;
      @(negedge clk);
      base_addr = 32'h300; dest_reg = 4'd12; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("reset_outputs", outs_flat(), 256'(0));
      repeat (3) @(negedge clk);
      chk("reset_outputs_held", outs_flat(), 256'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("no_partial_write", 256'(wr_count - wc0), 256'(0));
      chk("rf12_untouched", 256'(rf[12]), 256'(0));
    end

    r = '{32'h300, 4'd12, 0, 0,
          {32'h0F0F0F0F, 32'h76543210, 32'hFEDCBA98, 32'h55AA55AA},
          {32'h30C, 32'h308, 32'h304, 32'h300},
          128'h0F0F0F0F_76543210_FEDCBA98_55AA55AA, 4};
    run_load(r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
